wr_dec_scoreboard: RTL and testbench
====================================

WR_DEC_SCOREBOARD -- requirements
Module: wr_dec_scoreboard

Interface
REQ-001 Parameter AW, default 5: register-address width; NREG = 2**AW registers.
REQ-002 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired: never busy, never written.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Rst_n  in  1  reset, synchronous, active-low.
REQ-005 En  in  1  global enable; 0 freezes scoreboard and forces write enables to zero.
REQ-006 IssValid  in  1  issue request: instruction claims destination IssAddr.
REQ-007 IssAddr  in  AW  issue destination register.
REQ-008 IssReady  out  1  combinational; issue accepted when IssValid && IssReady.
REQ-009 WbValid  in  1  writeback request for WbAddr.
REQ-010 WbAddr  in  AW  writeback destination register.
REQ-011 WeY  out  NREG  registered one-hot register-file write enable.
REQ-012 RsAddr, RtAddr  in  AW each  source operands checked for RAW hazard.
REQ-013 Stall  out  1  combinational RAW-hazard indication.
REQ-014 Busy  out  NREG  registered pending-write vector.
REQ-015 Err  out  1  registered one-cycle pulse: writeback to non-busy register.

Function
REQ-016 IssReady SHALL equal En && !Busy[IssAddr], evaluated on current-cycle Busy; no same-cycle bypass from writeback.
REQ-017 With ZERO_REG=1 and IssAddr=0, IssReady SHALL be En; acceptance SHALL leave Busy unchanged.
REQ-018 An accepted issue SHALL set Busy[IssAddr] at the next edge (latency 1).
REQ-019 WbValid && En SHALL drive WeY to one-hot(WbAddr) at the next edge for exactly one cycle; otherwise WeY SHALL be all-zero at the next edge.
REQ-020 With ZERO_REG=1 and WbAddr=0, WeY SHALL be all-zero and Err SHALL stay 0.
REQ-021 WbValid && En SHALL clear Busy[WbAddr] at the next edge.
REQ-022 WbValid && En with Busy[WbAddr]=0 (and WbAddr not hardwired zero) SHALL pulse Err for one cycle; WeY still asserted.
REQ-023 Accepted issue and writeback to the same address in the same cycle SHALL leave that Busy bit set (set wins); per REQ-016 this occurs only when the bit is currently clear, so Err also pulses.
REQ-024 Issue and writeback to different addresses in the same cycle SHALL both take effect.
REQ-025 Stall SHALL equal En && ((Busy[RsAddr] && !(ZERO_REG && RsAddr==0)) || (Busy[RtAddr] && !(ZERO_REG && RtAddr==0))).
REQ-026 En=0 SHALL hold Busy, force IssReady=0, and produce WeY=0 and Err=0 at the next edge.
REQ-027 WeY SHALL never have more than one bit set.

Reset
REQ-028 Rst_n=0 at an edge SHALL set Busy=0, WeY=0, Err=0, overriding any same-cycle issue or writeback.
REQ-029 Reset mid-operation SHALL discard all pending writes; no WeY pulse SHALL follow for pre-reset issues.
REQ-030 Combinational outputs SHALL reflect the reset Busy value from the cycle after reset.

Structure
REQ-031 Shared package SHALL hold default AW, NREG derivation, and the one-hot function/constant width.
REQ-032 One sub-module, dec_onehot (parametrised AW-to-2**AW decoder with enable, combinational), SHALL be instantiated for both issue set-mask and writeback mask.
REQ-033 Target RTL size 120-400 lines; no memories, flops only.

Verification
REQ-034 Reset, then IssValid=1 IssAddr=5 -> IssReady=1; next cycle Busy=32'h00000020, RsAddr=5 gives Stall=1.
REQ-035 Busy[5]=1, IssAddr=5 -> IssReady=0; WbValid=1 WbAddr=5 -> next cycle WeY=32'h00000020 for one cycle, Busy[5]=0, Err=0.
REQ-036 WbValid=1 WbAddr=31 with Busy=0 -> next cycle WeY=32'h80000000, Err=1 for one cycle.
REQ-037 ZERO_REG=1: issue addr 0 and writeback addr 0 -> Busy unchanged, WeY=0, Err=0, Stall=0 for RsAddr=0.
REQ-038 Busy[3]=1, En=0 with WbValid=1 WbAddr=3 -> WeY=0, Busy[3] stays 1, IssReady=0; En=1 resumes.
REQ-039 Busy[7]=1, Rst_n=0 with IssValid IssAddr=9 same cycle -> Busy=0, WeY=0 after edge; AW=3 instance repeats REQ-034 with IssAddr=5 -> Busy=8'h20.

Source files
------------

// File: rtl/wr_dec_scoreboard_pkg.sv
// Shared sizing for the write-destination scoreboard: default address width,
// register-count derivation and a one-hot helper.
package wr_dec_scoreboard_pkg;

    localparam int unsigned AW_DEFAULT   = 5;
    localparam int unsigned NREG_DEFAULT = 1 << AW_DEFAULT;

    // Number of architectural registers addressed by an aw-bit index.
    function automatic int unsigned nreg_f(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    // One-hot encode an index of up to AW_DEFAULT bits into an NREG_DEFAULT vector.
    function automatic logic [NREG_DEFAULT-1:0] onehot_f(input logic [AW_DEFAULT-1:0] idx);
        logic [NREG_DEFAULT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wr_dec_scoreboard_dec_onehot.sv
// Combinational AW-to-2**AW one-hot decoder with enable; all-zero when disabled.
module dec_onehot
    import wr_dec_scoreboard_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic                  en_i,
    input  logic [AW-1:0]         addr_i,
    output logic [(1<<AW)-1:0]    mask_c_o
);

    always_comb begin
        mask_c_o = '0;
        if (en_i) begin
            mask_c_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/wr_dec_scoreboard.sv
// Register write-destination scoreboard: tracks pending writes, gates issue on
// busy destinations, flags RAW hazards and produces one-hot write enables.
module wr_dec_scoreboard
    import wr_dec_scoreboard_pkg::*;
#(
    parameter int unsigned AW       = AW_DEFAULT,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 iss_valid_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic                 iss_ready_c_o,
    input  logic                 wb_valid_i,
    input  logic [AW-1:0]        wb_addr_i,
    output logic [(1<<AW)-1:0]   we_y_o,
    input  logic [AW-1:0]        rs_addr_i,
    input  logic [AW-1:0]        rt_addr_i,
    output logic                 stall_c_o,
    output logic [(1<<AW)-1:0]   busy_o,
    output logic                 err_o
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] we_q,   we_d;
    logic            err_q,  err_d;

    logic            iss_zero, wb_zero, rs_zero, rt_zero;
    logic            iss_fire, wb_fire;
    logic [NREG-1:0] set_mask, wb_mask;

    // Hardwired-zero register detection per port.
    assign iss_zero = ZERO_REG && (iss_addr_i == '0);
    assign wb_zero  = ZERO_REG && (wb_addr_i  == '0);
    assign rs_zero  = ZERO_REG && (rs_addr_i  == '0);
    assign rt_zero  = ZERO_REG && (rt_addr_i  == '0);

    // Readiness looks only at the current busy state; a same-cycle writeback does not bypass.
    assign iss_ready_c_o = en_i && (iss_zero || !busy_q[iss_addr_i]);
    assign iss_fire      = iss_valid_i && iss_ready_c_o && !iss_zero;
    assign wb_fire       = en_i && wb_valid_i && !wb_zero;

    assign stall_c_o = en_i && ((busy_q[rs_addr_i] && !rs_zero) ||
                                (busy_q[rt_addr_i] && !rt_zero));

    dec_onehot #(.AW(AW)) u_dec_iss (
        .en_i     (iss_fire),
        .addr_i   (iss_addr_i),
        .mask_c_o (set_mask)
    );

    dec_onehot #(.AW(AW)) u_dec_wb (
        .en_i     (wb_fire),
        .addr_i   (wb_addr_i),
        .mask_c_o (wb_mask)
    );

    // Clear on writeback, then set on issue so a same-address collision stays busy.
    always_comb begin
        busy_d = (busy_q & ~wb_mask) | set_mask;
        we_d   = wb_mask;
        err_d  = wb_fire && !busy_q[wb_addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
            we_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign we_y_o = we_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_wr_dec_scoreboard.sv
// Directed vector bench for wr_dec_scoreboard: AW=5 table plus an AW=3 sequence.
module tb_wr_dec_scoreboard;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AW=5 instance
    logic        rst_n, en, iss_valid, wb_valid;
    logic [4:0]  iss_addr, wb_addr, rs_addr, rt_addr;
    logic        iss_ready, stall, err;
    logic [31:0] we_y, busy;

    wr_dec_scoreboard #(.AW(5), .ZERO_REG(1'b1)) u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .en_i          (en),
        .iss_valid_i   (iss_valid),
        .iss_addr_i    (iss_addr),
        .iss_ready_c_o (iss_ready),
        .wb_valid_i    (wb_valid),
        .wb_addr_i     (wb_addr),
        .we_y_o        (we_y),
        .rs_addr_i     (rs_addr),
        .rt_addr_i     (rt_addr),
        .stall_c_o     (stall),
        .busy_o        (busy),
        .err_o         (err)
    );

    // AW=3 instance
    logic       s_rst_n, s_en, s_iss_valid, s_wb_valid;
    logic [2:0] s_iss_addr, s_wb_addr, s_rs_addr, s_rt_addr;
    logic       s_iss_ready, s_stall, s_err;
    logic [7:0] s_we_y, s_busy;

    wr_dec_scoreboard #(.AW(3), .ZERO_REG(1'b1)) u_dut_s (
        .clk_i         (clk),
        .rst_n_i       (s_rst_n),
        .en_i          (s_en),
        .iss_valid_i   (s_iss_valid),
        .iss_addr_i    (s_iss_addr),
        .iss_ready_c_o (s_iss_ready),
        .wb_valid_i    (s_wb_valid),
        .wb_addr_i     (s_wb_addr),
        .we_y_o        (s_we_y),
        .rs_addr_i     (s_rs_addr),
        .rt_addr_i     (s_rt_addr),
        .stall_c_o     (s_stall),
        .busy_o        (s_busy),
        .err_o         (s_err)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        iss_valid;
        logic [4:0]  iss_addr;
        logic        wb_valid;
        logic [4:0]  wb_addr;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic        exp_ready;   // before the edge
        logic        exp_stall;   // before the edge
        logic [31:0] exp_busy;    // after the edge
        logic [31:0] exp_we;      // after the edge
        logic        exp_err;     // after the edge
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic iv, input logic [4:0] ia,
                       input logic wv, input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt,
                       input logic xr, input logic xs, input logic [31:0] xb,
                       input logic [31:0] xw, input logic xe);
        vec_t v;
        v.rst_n = r;  v.en = e;  v.iss_valid = iss_v(iv); v.iss_addr = ia;
        v.wb_valid = wv; v.wb_addr = wa; v.rs_addr = rs; v.rt_addr = rt;
        v.exp_ready = xr; v.exp_stall = xs; v.exp_busy = xb; v.exp_we = xw; v.exp_err = xe;
        vecs.push_back(v);
    endtask

    function automatic logic iss_v(input logic b);
        return b;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0;
        iss_addr = '0; wb_addr = '0; rs_addr = '0; rt_addr = '0;
        s_rst_n = 1'b0; s_en = 1'b0; s_iss_valid = 1'b0; s_wb_valid = 1'b0;
        s_iss_addr = '0; s_wb_addr = '0; s_rs_addr = '0; s_rt_addr = '0;

        //   rst en iv ia  wv wa  rs  rt   rdy stl busy          we            err
        add(0, 0, 0, 0,  0, 0,  0,  0,   0, 0, 32'h0,        32'h0,        0); // reset
        add(1, 1, 1, 5,  0, 0,  5,  0,   1, 0, 32'h20,       32'h0,        0); // issue r5
        add(1, 1, 1, 5,  1, 5,  5,  0,   0, 1, 32'h0,        32'h20,       0); // r5 busy, wb r5
        add(1, 1, 0, 0,  0, 0,  5,  0,   1, 0, 32'h0,        32'h0,        0); // we one cycle only
        add(1, 1, 0, 0,  1, 31, 0,  0,   1, 0, 32'h0,        32'h80000000, 1); // wb non-busy r31
        add(1, 1, 0, 0,  0, 0,  0,  0,   1, 0, 32'h0,        32'h0,        0); // err one cycle only
        add(1, 1, 1, 0,  1, 0,  0,  0,   1, 0, 32'h0,        32'h0,        0); // hardwired r0
        add(1, 1, 1, 3,  0, 0,  0,  0,   1, 0, 32'h8,        32'h0,        0); // issue r3
        add(1, 0, 1, 3,  1, 3,  3,  0,   0, 0, 32'h8,        32'h0,        0); // en=0 freeze
        add(1, 1, 0, 3,  1, 3,  3,  0,   0, 1, 32'h0,        32'h8,        0); // resume, wb r3
        add(1, 1, 1, 10, 1, 10, 0,  0,   1, 0, 32'h400,      32'h400,      1); // same addr: set wins
        add(1, 1, 1, 12, 1, 10, 0,  10,  1, 1, 32'h1000,     32'h400,      0); // different addrs
        add(1, 1, 1, 7,  0, 0,  0,  0,   1, 0, 32'h1080,     32'h0,        0); // issue r7
        add(0, 1, 1, 9,  1, 12, 7,  0,   1, 1, 32'h0,        32'h0,        0); // reset overrides
        add(1, 1, 0, 9,  0, 0,  7,  12,  1, 0, 32'h0,        32'h0,        0); // post-reset view
        add(1, 1, 0, 0,  0, 0,  0,  0,   1, 0, 32'h0,        32'h0,        0); // no stale we pulse

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; en = vecs[i].en;
            iss_valid = vecs[i].iss_valid; iss_addr = vecs[i].iss_addr;
            wb_valid = vecs[i].wb_valid;   wb_addr = vecs[i].wb_addr;
            rs_addr = vecs[i].rs_addr;     rt_addr = vecs[i].rt_addr;
            #1;
            if (i > 0) begin
                chk("iss_ready", i, 32'(iss_ready), 32'(vecs[i].exp_ready));
                chk("stall",     i, 32'(stall),     32'(vecs[i].exp_stall));
            end
            @(posedge clk);
            #1;
            chk("busy",   i, busy, vecs[i].exp_busy);
            chk("we_y",   i, we_y, vecs[i].exp_we);
            chk("err",    i, 32'(err), 32'(vecs[i].exp_err));
            chk("onehot", i, 32'($countones(we_y) <= 1), 32'(1));
        end

        // AW=3 sequence: reset, issue r5, check busy/stall, then writeback r5
        @(negedge clk);
        s_rst_n = 1'b0;
        @(posedge clk); #1;
        chk("s_busy_rst", 0, 32'(s_busy), 32'h0);
        @(negedge clk);
        s_rst_n = 1'b1; s_en = 1'b1; s_iss_valid = 1'b1; s_iss_addr = 3'd5; s_rs_addr = 3'd5;
        #1;
        chk("s_ready", 1, 32'(s_iss_ready), 32'h1);
        chk("s_stall_pre", 1, 32'(s_stall), 32'h0);
        @(posedge clk); #1;
        chk("s_busy", 1, 32'(s_busy), 32'h20);
        chk("s_stall", 1, 32'(s_stall), 32'h1);
        chk("s_ready_busy", 1, 32'(s_iss_ready), 32'h0);
        @(negedge clk);
        s_iss_valid = 1'b0; s_wb_valid = 1'b1; s_wb_addr = 3'd5;
        @(posedge clk); #1;
        chk("s_we", 2, 32'(s_we_y), 32'h20);
        chk("s_busy_clr", 2, 32'(s_busy), 32'h0);
        chk("s_err", 2, 32'(s_err), 32'h0);
        @(negedge clk);
        s_wb_valid = 1'b0;
        @(posedge clk); #1;
        chk("s_we_off", 3, 32'(s_we_y), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
